// File: rtl/ocx_dlx_rx_lane_trn.sv
// ocx_dlx_rx_lane_trn
//
// Per-lane RX training and data recovery. Each beat from the gearbox is
// descrambled, fully bit-reversed back into flit order, then parity-checked
// and classified as a deskew, TS1, TS2, TS3 or ordinary beat. A
// deskew-periodicity state machine (HUNT -> SYNC -> LOCKED) tracks whether
// deskews keep arriving exactly 32 valid beats apart.
//
// Ports
//   dlx_clk, dlx_reset_n   clock, asynchronous active-low reset
//   gb_rx_data/odd/valid   scrambled beat, its parity bit, beat qualifier
//   ctl_rx_lane_scrambler  keystream aligned to gb_rx_data
//   ctl_rx_lane            expected lane number carried by deskews
//   ctl_rx_retrain         synchronous force back to HUNT
//   rx_flt_data/valid      recovered flit-order data and its qualifier
//   rx_ctl_*               training pulses, captured fields, parity status, lock
module ocx_dlx_rx_lane_trn (
    input  logic        dlx_clk,
    input  logic        dlx_reset_n,
    input  logic [63:0] gb_rx_data,
    input  logic        gb_rx_odd,
    input  logic        gb_rx_valid,
    input  logic [63:0] ctl_rx_lane_scrambler,
    input  logic [2:0]  ctl_rx_lane,
    input  logic        ctl_rx_retrain,
    output logic [63:0] rx_flt_data,
    output logic        rx_flt_valid,
    output logic        rx_ctl_ts1,
    output logic        rx_ctl_ts2,
    output logic        rx_ctl_ts3,
    output logic [15:0] rx_ctl_good_lanes,
    output logic        rx_ctl_deskew,
    output logic [18:0] rx_ctl_deskew_val,
    output logic        rx_ctl_lane_err,
    output logic        rx_ctl_parity_err,
    output logic [7:0]  rx_ctl_parity_cnt,
    output logic        rx_ctl_locked
);

    typedef enum logic [1:0] {StHunt, StSync, StLocked} state_e;

    state_e      state_q, state_d;
    logic [4:0]  bcnt_q, bcnt_d;
    logic [1:0]  mcnt_q, mcnt_d;
    logic [1:0]  xcnt_q, xcnt_d;

    logic [63:0] flt_data_q;
    logic        flt_valid_q;
    logic        ts1_q, ts2_q, ts3_q, deskew_q, lane_err_q, parity_err_q;
    logic [15:0] good_lanes_q;
    logic [18:0] deskew_val_q;
    logic [7:0]  parity_cnt_q;

    logic [63:0] descr;
    logic [63:0] rev;
    logic [63:0] pat;
    logic        is_deskew, is_ts1, is_ts2, is_ts3;
    logic        par_err;
    logic        expected;

    // Descramble, reverse all 64 bits, then byte-swap to get the pattern word.
    always_comb begin
        descr = gb_rx_data ^ ctl_rx_lane_scrambler;
        rev   = '0;
        pat   = '0;
        for (int i = 0; i < 64; i++) begin
            rev[i] = descr[63-i];
        end
        for (int b = 0; b < 8; b++) begin
            pat[8*b +: 8] = rev[8*(7-b) +: 8];
        end
    end

    // Priority: deskew first, then TS1, TS2, TS3.
    assign is_deskew = (pat[63:24] == 40'h4B1E1E1E1E) && (pat[4:3] == 2'b00);
    assign is_ts1    = !is_deskew && (pat == 64'h4B4A4A4A4A4A4A4A);
    assign is_ts2    = !is_deskew && !is_ts1 && (pat[63:16] == 48'h4B4545454545);
    assign is_ts3    = !is_deskew && !is_ts1 && !is_ts2 && (pat[63:16] == 48'h4B4141414141);
    assign par_err   = gb_rx_valid && ((^rev) != gb_rx_odd);
    assign expected  = (bcnt_q == 5'd31);

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        mcnt_d  = mcnt_q;
        xcnt_d  = xcnt_q;
        if (gb_rx_valid) begin
            bcnt_d = is_deskew ? 5'd0 : bcnt_q + 5'd1;
            unique case (state_q)
                StHunt: begin
                    if (is_deskew) begin
                        state_d = StSync;
                        mcnt_d  = 2'd0;
                    end
                end
                StSync: begin
                    if (expected) begin
                        if (is_deskew) begin
                            mcnt_d = mcnt_q + 2'd1;
                            if (mcnt_q == 2'd1) begin
                                state_d = StLocked;
                                xcnt_d  = 2'd0;
                            end
                        end else begin
                            state_d = StHunt;
                        end
                    end else if (is_deskew) begin
                        // Off-position deskew re-anchors the period.
                        mcnt_d = 2'd0;
                    end
                end
                StLocked: begin
                    if (expected) begin
                        if (is_deskew) begin
                            xcnt_d = 2'd0;
                        end else if (xcnt_q == 2'd1) begin
                            state_d = StHunt;
                            xcnt_d  = 2'd0;
                        end else begin
                            xcnt_d = xcnt_q + 2'd1;
                        end
                    end else if (is_deskew) begin
                        state_d = StSync;
                        mcnt_d  = 2'd0;
                    end
                end
                default: state_d = StHunt;
            endcase
        end
        if (ctl_rx_retrain) begin
            state_d = StHunt;
            bcnt_d  = 5'd0;
            mcnt_d  = 2'd0;
            xcnt_d  = 2'd0;
        end
    end

    always_ff @(posedge dlx_clk or negedge dlx_reset_n) begin
        if (!dlx_reset_n) begin
            state_q      <= StHunt;
            bcnt_q       <= '0;
            mcnt_q       <= '0;
            xcnt_q       <= '0;
            flt_data_q   <= '0;
            flt_valid_q  <= 1'b0;
            ts1_q        <= 1'b0;
            ts2_q        <= 1'b0;
            ts3_q        <= 1'b0;
            deskew_q     <= 1'b0;
            lane_err_q   <= 1'b0;
            parity_err_q <= 1'b0;
            good_lanes_q <= '0;
            deskew_val_q <= '0;
            parity_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            bcnt_q       <= bcnt_d;
            mcnt_q       <= mcnt_d;
            xcnt_q       <= xcnt_d;
            flt_valid_q  <= gb_rx_valid;
            ts1_q        <= gb_rx_valid && is_ts1;
            ts2_q        <= gb_rx_valid && is_ts2;
            ts3_q        <= gb_rx_valid && is_ts3;
            deskew_q     <= gb_rx_valid && is_deskew;
            lane_err_q   <= gb_rx_valid && is_deskew && (pat[2:0] != ctl_rx_lane);
            parity_err_q <= par_err;
            if (gb_rx_valid) begin
                flt_data_q <= rev;
                if (is_ts2 || is_ts3) begin
                    good_lanes_q <= pat[15:0];
                end
                if (is_deskew) begin
                    deskew_val_q <= pat[23:5];
                end
            end
            if (par_err && (parity_cnt_q != 8'hFF)) begin
                parity_cnt_q <= parity_cnt_q + 8'd1;
            end
        end
    end

    assign rx_flt_data       = flt_data_q;
    assign rx_flt_valid      = flt_valid_q;
    assign rx_ctl_ts1        = ts1_q;
    assign rx_ctl_ts2        = ts2_q;
    assign rx_ctl_ts3        = ts3_q;
    assign rx_ctl_good_lanes = good_lanes_q;
    assign rx_ctl_deskew     = deskew_q;
    assign rx_ctl_deskew_val = deskew_val_q;
    assign rx_ctl_lane_err   = lane_err_q;
    assign rx_ctl_parity_err = parity_err_q;
    assign rx_ctl_parity_cnt = parity_cnt_q;
    assign rx_ctl_locked     = (state_q == StLocked);

endmodule

// File: tb/tb_ocx_dlx_rx_lane_trn.sv
// Bench for ocx_dlx_rx_lane_trn: directed scenarios plus a randomized phase,
// all checked every cycle against a behavioural model of the lane receiver.
module tb_ocx_dlx_rx_lane_trn;

    logic        dlx_clk = 1'b0;
    logic        dlx_reset_n;
    logic [63:0] gb_rx_data;
    logic        gb_rx_odd;
    logic        gb_rx_valid;
    logic [63:0] ctl_rx_lane_scrambler;
    logic [2:0]  ctl_rx_lane;
    logic        ctl_rx_retrain;
    logic [63:0] rx_flt_data;
    logic        rx_flt_valid;
    logic        rx_ctl_ts1, rx_ctl_ts2, rx_ctl_ts3;
    logic [15:0] rx_ctl_good_lanes;
    logic        rx_ctl_deskew;
    logic [18:0] rx_ctl_deskew_val;
    logic        rx_ctl_lane_err;
    logic        rx_ctl_parity_err;
    logic [7:0]  rx_ctl_parity_cnt;
    logic        rx_ctl_locked;

    always #5 dlx_clk = ~dlx_clk;

    ocx_dlx_rx_lane_trn dut (
        .dlx_clk               (dlx_clk),
        .dlx_reset_n           (dlx_reset_n),
        .gb_rx_data            (gb_rx_data),
        .gb_rx_odd             (gb_rx_odd),
        .gb_rx_valid           (gb_rx_valid),
        .ctl_rx_lane_scrambler (ctl_rx_lane_scrambler),
        .ctl_rx_lane           (ctl_rx_lane),
        .ctl_rx_retrain        (ctl_rx_retrain),
        .rx_flt_data           (rx_flt_data),
        .rx_flt_valid          (rx_flt_valid),
        .rx_ctl_ts1            (rx_ctl_ts1),
        .rx_ctl_ts2            (rx_ctl_ts2),
        .rx_ctl_ts3            (rx_ctl_ts3),
        .rx_ctl_good_lanes     (rx_ctl_good_lanes),
        .rx_ctl_deskew         (rx_ctl_deskew),
        .rx_ctl_deskew_val     (rx_ctl_deskew_val),
        .rx_ctl_lane_err       (rx_ctl_lane_err),
        .rx_ctl_parity_err     (rx_ctl_parity_err),
        .rx_ctl_parity_cnt     (rx_ctl_parity_cnt),
        .rx_ctl_locked         (rx_ctl_locked)
    );

    localparam logic [63:0] Ts1Pat = 64'h4B4A4A4A4A4A4A4A;

    int n_checks = 0;
    int n_pass   = 0;
    bit zero_scr = 1'b0;
    int stalls_left = 0;
    int perr_seen = 0;

    // Behavioural model state: expected registered outputs.
    logic [63:0] m_flt;
    logic        m_valid, m_ts1, m_ts2, m_ts3, m_desk, m_lerr, m_perr;
    logic [15:0] m_good;
    logic [18:0] m_dval;
    int          m_pcnt;
    int          m_mode;   // 0 hunt, 1 sync, 2 locked
    int          m_since;  // valid beats since the last deskew / reset / retrain
    int          m_match, m_miss;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    function automatic logic [63:0] bswap(input logic [63:0] x);
        logic [63:0] y;
        for (int b = 0; b < 8; b++) y[8*b +: 8] = x[8*(7-b) +: 8];
        return y;
    endfunction

    function automatic logic [63:0] bitrev(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[i] = x[63-i];
        return y;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [63:0] desk_pat(input logic [18:0] val, input logic [2:0] lane);
        return {40'h4B1E1E1E1E, val, 2'b00, lane};
    endfunction

    task automatic model_reset();
        m_flt = '0; m_valid = 0; m_ts1 = 0; m_ts2 = 0; m_ts3 = 0; m_desk = 0;
        m_lerr = 0; m_perr = 0; m_good = '0; m_dval = '0; m_pcnt = 0;
        m_mode = 0; m_since = 0; m_match = 0; m_miss = 0;
    endtask

    // Apply the receive rules to the beat currently on the inputs.
    task automatic model_step();
        logic [63:0] r, p;
        bit desk, on_time;
        m_valid = gb_rx_valid;
        m_ts1 = 0; m_ts2 = 0; m_ts3 = 0; m_desk = 0; m_lerr = 0; m_perr = 0;
        if (gb_rx_valid) begin
            r = bitrev(gb_rx_data ^ ctl_rx_lane_scrambler);
            p = bswap(r);
            m_flt = r;
            desk = (p[63:24] == 40'h4B1E1E1E1E) && (p[4:3] == 2'b00);
            if (desk) begin
                m_desk = 1;
                m_dval = p[23:5];
                m_lerr = (p[2:0] != ctl_rx_lane);
            end else if (p == Ts1Pat) begin
                m_ts1 = 1;
            end else if (p[63:16] == 48'h4B4545454545) begin
                m_ts2 = 1; m_good = p[15:0];
            end else if (p[63:16] == 48'h4B4141414141) begin
                m_ts3 = 1; m_good = p[15:0];
            end
            m_perr = ((^r) != gb_rx_odd);
            if (m_perr && m_pcnt < 255) m_pcnt++;
            on_time = (m_since % 32) == 31;
            case (m_mode)
                0: if (desk) begin m_mode = 1; m_match = 0; end
                1: begin
                    if (on_time) begin
                        if (desk) begin
                            m_match++;
                            if (m_match == 2) begin m_mode = 2; m_miss = 0; end
                        end else m_mode = 0;
                    end else if (desk) m_match = 0;
                end
                default: begin
                    if (on_time) begin
                        if (desk) m_miss = 0;
                        else begin
                            m_miss++;
                            if (m_miss == 2) m_mode = 0;
                        end
                    end else if (desk) begin m_mode = 1; m_match = 0; end
                end
            endcase
            m_since = desk ? 0 : m_since + 1;
        end
        if (ctl_rx_retrain) begin
            m_mode = 0; m_since = 0; m_match = 0; m_miss = 0;
        end
    endtask

    task automatic compare_all();
        chk("flt_data",   rx_flt_data, m_flt);
        chk("flt_valid",  64'(rx_flt_valid), 64'(m_valid));
        chk("ts1",        64'(rx_ctl_ts1), 64'(m_ts1));
        chk("ts2",        64'(rx_ctl_ts2), 64'(m_ts2));
        chk("ts3",        64'(rx_ctl_ts3), 64'(m_ts3));
        chk("good_lanes", 64'(rx_ctl_good_lanes), 64'(m_good));
        chk("deskew",     64'(rx_ctl_deskew), 64'(m_desk));
        chk("deskew_val", 64'(rx_ctl_deskew_val), 64'(m_dval));
        chk("lane_err",   64'(rx_ctl_lane_err), 64'(m_lerr));
        chk("parity_err", 64'(rx_ctl_parity_err), 64'(m_perr));
        chk("parity_cnt", 64'(rx_ctl_parity_cnt), 64'(m_pcnt));
        chk("locked",     64'(rx_ctl_locked), 64'(m_mode == 2));
    endtask

    // One clock: drive inputs, advance model, sample 1 time unit after the edge.
    task automatic beat(input logic [63:0] raw, input logic odd, input logic vld,
                        input logic [63:0] scr, input logic rtr);
        gb_rx_data = raw;
        gb_rx_odd = odd;
        gb_rx_valid = vld;
        ctl_rx_lane_scrambler = scr;
        ctl_rx_retrain = rtr;
        model_step();
        @(posedge dlx_clk);
        #1;
        compare_all();
        if (rx_ctl_parity_err) perr_seen++;
        ctl_rx_retrain = 1'b0;
    endtask

    // Encode pattern word p the way the TX lane path would.
    task automatic send_p(input logic [63:0] p, input bit bad, input bit rtr);
        logic [63:0] scr, r;
        scr = zero_scr ? 64'd0 : rand64();
        r = bswap(p);
        beat(bitrev(r) ^ scr, (^r) ^ bad, 1'b1, scr, rtr);
    endtask

    task automatic stall(input bit rtr);
        beat(rand64(), 1'($urandom_range(0, 1)), 1'b0, rand64(), rtr);
    endtask

    task automatic maybe_stall();
        if (stalls_left > 0 && $urandom_range(0, 15) == 0) begin
            stall(0);
            stalls_left--;
        end
    endtask

    // One deskew period: deskew (or a TS2 in its place) then 31 TS2 beats.
    task automatic period(input bit desk, input int lock_chk);
        maybe_stall();
        if (desk) send_p(desk_pat(19'h1ABCD, 3'd3), 0, 0);
        else send_p({48'h4B4545454545, 16'hFF00}, 0, 0);
        if (lock_chk >= 0) chk("locked_after_period_start", 64'(rx_ctl_locked), 64'(lock_chk));
        for (int i = 0; i < 31; i++) begin
            maybe_stall();
            send_p({48'h4B4545454545, 16'hFF00}, 0, 0);
        end
    endtask

    task automatic async_reset();
        gb_rx_valid = 1'b0;
        dlx_reset_n = 1'b0;
        model_reset();
        #1;
        chk("reset_locked", 64'(rx_ctl_locked), 64'd0);
        chk("reset_pcnt", 64'(rx_ctl_parity_cnt), 64'd0);
        compare_all();
        @(posedge dlx_clk);
        #1;
        dlx_reset_n = 1'b1;
    endtask

    initial begin
        logic [63:0] p;
        int since;
        dlx_reset_n = 1'b0;
        gb_rx_data = '0;
        gb_rx_odd = 1'b0;
        gb_rx_valid = 1'b0;
        ctl_rx_lane_scrambler = '0;
        ctl_rx_lane = 3'd3;
        ctl_rx_retrain = 1'b0;
        model_reset();
        repeat (2) @(posedge dlx_clk);
        #1;
        chk("init_locked", 64'(rx_ctl_locked), 64'd0);
        chk("init_flt_data", rx_flt_data, 64'd0);
        chk("init_flt_valid", 64'(rx_flt_valid), 64'd0);
        compare_all();
        dlx_reset_n = 1'b1;

        // Continuous TS1 with a zero keystream.
        zero_scr = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send_p(Ts1Pat, 0, 0);
            chk("ts1_every_cycle", 64'(rx_ctl_ts1), 64'd1);
        end
        chk("ts1_not_locked", 64'(rx_ctl_locked), 64'd0);
        chk("ts1_pcnt", 64'(rx_ctl_parity_cnt), 64'd0);
        zero_scr = 1'b0;

        // Periodic deskews with 5 stalls spread through: lock, then misses.
        stalls_left = 5;
        period(1, 0);
        chk("deskew_pulse", 64'(rx_ctl_deskew), 64'd0);
        period(1, 0);
        period(1, 1);
        chk("deskew_val", 64'(rx_ctl_deskew_val), 64'h1ABCD);
        chk("good_lanes", 64'(rx_ctl_good_lanes), 64'hFF00);
        chk("no_lane_err", 64'(rx_ctl_lane_err), 64'd0);
        period(1, 1);
        period(0, 1);   // single miss keeps lock
        period(1, 1);
        period(0, 1);
        period(0, 0);   // second consecutive miss drops lock
        chk("stalls_used", 64'(stalls_left), 64'd0);

        // 300 corrupted-parity beats of ordinary data.
        perr_seen = 0;
        for (int i = 0; i < 300; i++) send_p(64'hEFCDAB8967452301 ^ 64'(i), 1, 0);
        chk("parity_pulses", 64'(perr_seen), 64'd300);
        chk("parity_sat", 64'(rx_ctl_parity_cnt), 64'hFF);

        // Flit data round trip, then a wrong-lane deskew.
        ctl_rx_lane = 3'd2;
        send_p(bswap(64'h0123456789ABCDEF), 0, 0);
        chk("flit_data", rx_flt_data, 64'h0123456789ABCDEF);
        chk("flit_no_flags", 64'({rx_ctl_ts1, rx_ctl_ts2, rx_ctl_ts3, rx_ctl_deskew}), 64'd0);
        send_p(desk_pat(19'h00042, 3'd5), 0, 0);
        chk("lane_err_pulse", 64'(rx_ctl_lane_err), 64'd1);
        ctl_rx_lane = 3'd3;
        send_p(Ts1Pat, 0, 0);
        chk("lane_err_one_cycle", 64'(rx_ctl_lane_err), 64'd0);

        // Retrain to a known HUNT, lock, then reset mid-lock and relock.
        stall(1);
        period(1, 0);
        period(1, 0);
        period(1, 1);
        for (int i = 0; i < 7; i++) send_p({48'h4B4141414141, 16'h1234}, 0, 0);
        async_reset();
        period(1, 0);
        period(1, 0);
        period(1, 1);
        // Retrain mid-lock clears on the next edge, even on a deskew beat.
        send_p(desk_pat(19'h1ABCD, 3'd3), 0, 1);
        chk("retrain_drop", 64'(rx_ctl_locked), 64'd0);
        for (int i = 0; i < 31; i++) send_p(Ts1Pat, 0, 0);
        period(1, 0);
        period(1, 0);
        period(1, 1);

        // Randomized traffic with mostly periodic deskews.
        since = 0;
        for (int n = 0; n < 2500; n++) begin
            bit rtr, desk;
            rtr = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 299) == 0) ctl_rx_lane = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 99) >= 85) begin
                stall(rtr);
            end else begin
                desk = (since == 31 && $urandom_range(0, 99) < 85) ||
                       ($urandom_range(0, 99) < 2);
                if (desk) begin
                    p = desk_pat(19'($urandom),
                                 ($urandom_range(0, 9) == 0) ? 3'($urandom) : ctl_rx_lane);
                end else begin
                    case ($urandom_range(0, 5))
                        0: p = Ts1Pat;
                        1: p = {48'h4B4545454545, 16'($urandom)};
                        2: p = {48'h4B4141414141, 16'($urandom)};
                        3: p = {40'h4B1E1E1E1E, 19'($urandom), 2'($urandom_range(1, 3)), 3'($urandom)};
                        default: p = rand64();
                    endcase
                end
                since = desk ? 0 : (since + 1) % 32;
                send_p(p, ($urandom_range(0, 9) == 0), rtr);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
